// File: rtl/instr_type.sv
// Shared types and encodings for the SYSTEM-opcode decode stage.
package instr_type;

   typedef enum logic [3:0] {
      sysk_invalid = 4'd0,
      sysk_ecall,
      sysk_ebreak,
      sysk_csrrw,
      sysk_csrrs,
      sysk_csrrc,
      sysk_csrrwi,
      sysk_csrrsi,
      sysk_csrrci,
      sysk_mret,
      sysk_sret,
      sysk_wfi
   } system_kind_t;

   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

   localparam logic [11:0] F12_ECALL  = 12'h000;
   localparam logic [11:0] F12_EBREAK = 12'h001;
   localparam logic [11:0] F12_MRET   = 12'h302;
   localparam logic [11:0] F12_SRET   = 12'h102;
   localparam logic [11:0] F12_WFI    = 12'h105;

   localparam logic [1:0]  PRIV_U = 2'd0;
   localparam logic [1:0]  PRIV_S = 2'd1;
   localparam logic [1:0]  PRIV_M = 2'd3;

   // One decoded result, minus the sideband tag (its width is a stage parameter).
   typedef struct packed {
      system_kind_t kind;
      logic [11:0]  csr_addr;
      logic [4:0]   rd;
      logic [4:0]   rs1_uimm;
      logic         csr_re;
      logic         csr_we;
      logic         illegal;
   } sys_dec_t;

   function automatic logic is_csr_kind(input system_kind_t k);
      return (k == sysk_csrrw)  || (k == sysk_csrrs)  || (k == sysk_csrrc) ||
             (k == sysk_csrrwi) || (k == sysk_csrrsi) || (k == sysk_csrrci);
   endfunction

endpackage

// File: rtl/system_decode_comb.sv
// Combinational SYSTEM decoder: instruction word + privilege -> kind, CSR enables, legality.
module system_decode_comb
   import instr_type::*;
#(
   parameter int PRIV_EN      = 1,
   parameter int CSR_CHECK_EN = 1
) (
   input  logic [31:0]  instr,
   input  logic [1:0]   priv,
   output system_kind_t kind,
   output logic         csr_re,
   output logic         csr_we,
   output logic         illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [11:0] funct12;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign rd      = instr[11:7];
   assign rs1     = instr[19:15];
   assign funct12 = instr[31:20];

   always_comb begin
      kind    = sysk_invalid;
      csr_re  = 1'b0;
      csr_we  = 1'b0;
      illegal = 1'b0;

      if (opcode != OPC_SYSTEM) begin
         illegal = 1'b1;
      end else begin
         case (funct3)
            3'b000: begin
               illegal = (rd != 5'd0) || (rs1 != 5'd0);
               case (funct12)
                  F12_ECALL:  kind = sysk_ecall;
                  F12_EBREAK: kind = sysk_ebreak;
                  F12_MRET: begin
                     kind = sysk_mret;
                     if (PRIV_EN == 0 || priv != PRIV_M) illegal = 1'b1;
                  end
                  F12_SRET: begin
                     kind = sysk_sret;
                     if (PRIV_EN == 0 || priv == PRIV_U) illegal = 1'b1;
                  end
                  F12_WFI: begin
                     kind = sysk_wfi;
                     if (PRIV_EN == 0) illegal = 1'b1;
                  end
                  default: illegal = 1'b1;
               endcase
            end
            3'b001: begin kind = sysk_csrrw;  csr_we = 1'b1; csr_re = (rd != 5'd0); end
            3'b101: begin kind = sysk_csrrwi; csr_we = 1'b1; csr_re = (rd != 5'd0); end
            3'b010: begin kind = sysk_csrrs;  csr_re = 1'b1; csr_we = (rs1 != 5'd0); end
            3'b011: begin kind = sysk_csrrc;  csr_re = 1'b1; csr_we = (rs1 != 5'd0); end
            3'b110: begin kind = sysk_csrrsi; csr_re = 1'b1; csr_we = (rs1 != 5'd0); end
            3'b111: begin kind = sysk_csrrci; csr_re = 1'b1; csr_we = (rs1 != 5'd0); end
            default: illegal = 1'b1;
         endcase

         // CSR address bits [9:8] encode the lowest privilege allowed; [11:10]=11 is read-only.
         if (CSR_CHECK_EN != 0 && is_csr_kind(kind)) begin
            if (funct12[9:8] > priv) illegal = 1'b1;
            if (funct12[11:10] == 2'b11 && csr_we) illegal = 1'b1;
         end
      end

      if (illegal) begin
         csr_re = 1'b0;
         csr_we = 1'b0;
      end
   end

endmodule

// File: rtl/decode_system_stage.sv
// SYSTEM decode pipeline stage: one-cycle decode into a registered output with a one-deep skid.
module decode_system_stage
   import instr_type::*;
#(
   parameter int TAG_W        = 32,
   parameter int PRIV_EN      = 1,
   parameter int CSR_CHECK_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [1:0]       in_priv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output system_kind_t     out_kind,
   output logic [11:0]      out_csr_addr,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1_uimm,
   output logic             out_csr_re,
   output logic             out_csr_we,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   system_kind_t dec_kind;
   logic         dec_re;
   logic         dec_we;
   logic         dec_illegal;
   sys_dec_t     dec_in;

   system_decode_comb #(
      .PRIV_EN      (PRIV_EN),
      .CSR_CHECK_EN (CSR_CHECK_EN)
   ) u_decode (
      .instr   (in_instr),
      .priv    (in_priv),
      .kind    (dec_kind),
      .csr_re  (dec_re),
      .csr_we  (dec_we),
      .illegal (dec_illegal)
   );

   always_comb begin
      dec_in          = '0;
      dec_in.kind     = dec_kind;
      dec_in.csr_addr = in_instr[31:20];
      dec_in.rd       = in_instr[11:7];
      dec_in.rs1_uimm = in_instr[19:15];
      dec_in.csr_re   = dec_re;
      dec_in.csr_we   = dec_we;
      dec_in.illegal  = dec_illegal;
   end

   sys_dec_t         out_reg,        out_next;
   logic [TAG_W-1:0] out_tag_reg,    out_tag_next;
   logic             out_valid_reg,  out_valid_next;
   sys_dec_t         skid_reg,       skid_next;
   logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
   logic             skid_valid_reg, skid_valid_next;
   logic             in_ready_reg,   in_ready_next;

   logic accept;
   logic out_free;

   assign accept   = in_valid & in_ready_reg;
   assign out_free = ~out_valid_reg | out_ready;

   always_comb begin
      out_next        = out_reg;
      out_tag_next    = out_tag_reg;
      out_valid_next  = out_valid_reg;
      skid_next       = skid_reg;
      skid_tag_next   = skid_tag_reg;
      skid_valid_next = skid_valid_reg;

      if (out_free) begin
         if (skid_valid_reg) begin
            // Oldest entry lives in the skid; a same-cycle input refills it.
            out_next       = skid_reg;
            out_tag_next   = skid_tag_reg;
            out_valid_next = 1'b1;
            if (accept) begin
               skid_next     = dec_in;
               skid_tag_next = in_tag;
            end else begin
               skid_valid_next = 1'b0;
            end
         end else begin
            out_valid_next = accept;
            if (accept) begin
               out_next     = dec_in;
               out_tag_next = in_tag;
            end
         end
      end else if (accept) begin
         skid_next       = dec_in;
         skid_tag_next   = in_tag;
         skid_valid_next = 1'b1;
      end

      in_ready_next = ~skid_valid_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg        <= '0;
         out_tag_reg    <= '0;
         out_valid_reg  <= 1'b0;
         skid_reg       <= '0;
         skid_tag_reg   <= '0;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b1;
      end else if (flush) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b1;
      end else begin
         out_reg        <= out_next;
         out_tag_reg    <= out_tag_next;
         out_valid_reg  <= out_valid_next;
         skid_reg       <= skid_next;
         skid_tag_reg   <= skid_tag_next;
         skid_valid_reg <= skid_valid_next;
         in_ready_reg   <= in_ready_next;
      end
   end

   assign in_ready     = in_ready_reg;
   assign out_valid    = out_valid_reg;
   assign out_kind     = out_reg.kind;
   assign out_csr_addr = out_reg.csr_addr;
   assign out_rd       = out_reg.rd;
   assign out_rs1_uimm = out_reg.rs1_uimm;
   assign out_csr_re   = out_reg.csr_re;
   assign out_csr_we   = out_reg.csr_we;
   assign out_illegal  = out_reg.illegal;
   assign out_tag      = out_tag_reg;

endmodule

// File: tb/tb_decode_system_stage.sv
// Bench for decode_system_stage: decode vector table through a scoreboard, then skid/flush/reset sequences.
module tb_decode_system_stage;
   import instr_type::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [31:0]  in_instr = '0;
   logic [1:0]   in_priv = '0;
   logic [31:0]  in_tag = '0;
   logic         out_ready = 1'b1;

   logic         in_ready, out_valid, out_csr_re, out_csr_we, out_illegal;
   system_kind_t out_kind;
   logic [11:0]  out_csr_addr;
   logic [4:0]   out_rd, out_rs1_uimm;
   logic [31:0]  out_tag;

   logic         np_in_ready, np_valid, np_csr_re, np_csr_we, np_illegal;
   system_kind_t np_kind;
   logic [11:0]  np_csr_addr;
   logic [4:0]   np_rd, np_rs1_uimm;
   logic [31:0]  np_tag;

   always #5 clk = ~clk;

   decode_system_stage #(.TAG_W(32), .PRIV_EN(1), .CSR_CHECK_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_priv(in_priv), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_csr_addr(out_csr_addr), .out_rd(out_rd), .out_rs1_uimm(out_rs1_uimm),
      .out_csr_re(out_csr_re), .out_csr_we(out_csr_we), .out_illegal(out_illegal),
      .out_tag(out_tag)
   );

   // Second instance with privileged decode and CSR checks disabled.
   decode_system_stage #(.TAG_W(32), .PRIV_EN(0), .CSR_CHECK_EN(0)) dut_np (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(np_in_ready), .in_instr(in_instr),
      .in_priv(in_priv), .in_tag(in_tag),
      .out_valid(np_valid), .out_ready(out_ready), .out_kind(np_kind),
      .out_csr_addr(np_csr_addr), .out_rd(np_rd), .out_rs1_uimm(np_rs1_uimm),
      .out_csr_re(np_csr_re), .out_csr_we(np_csr_we), .out_illegal(np_illegal),
      .out_tag(np_tag)
   );

   typedef struct {
      logic [31:0]  instr;
      logic [1:0]   priv;
      system_kind_t kind;
      logic         re;
      logic         we;
      logic         ill;
      logic         ill_np;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] tag;
      logic        chk_np;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   exp_t exp_cur;
   logic chk_np = 1'b0;
   logic drain_chk = 1'b0;
   logic [31:0] tag_ctr = 32'h1000;
   vec_t tbl[18];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (drain_chk && q.size() != 0) begin
            total++;
            if (!out_valid) begin
               bad++;
               $display("FAIL drain_gap: out_valid=0 with %0d pending, expected 1", q.size());
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out: tag=%h kind=%s with empty scoreboard", out_tag, out_kind.name());
            end else begin
               e = q.pop_front();
               if ({out_kind, out_csr_re, out_csr_we, out_illegal, out_tag,
                    out_csr_addr, out_rd, out_rs1_uimm} !==
                   {e.v.kind, e.v.re, e.v.we, e.v.ill, e.tag,
                    e.v.instr[31:20], e.v.instr[11:7], e.v.instr[19:15]}) begin
                  bad++;
                  $display("FAIL decode %h: got kind=%s re=%b we=%b ill=%b tag=%h addr=%h rd=%0d rs1=%0d expected kind=%s re=%b we=%b ill=%b tag=%h",
                           e.v.instr, out_kind.name(), out_csr_re, out_csr_we, out_illegal, out_tag,
                           out_csr_addr, out_rd, out_rs1_uimm,
                           e.v.kind.name(), e.v.re, e.v.we, e.v.ill, e.tag);
               end else begin
                  $display("txn instr=%h priv=%0d tag=%h kind=%s re=%b we=%b ill=%b",
                           e.v.instr, e.v.priv, out_tag, out_kind.name(), out_csr_re, out_csr_we, out_illegal);
               end
               if (e.chk_np) begin
                  total++;
                  if ({np_valid, np_illegal, np_tag} !== {1'b1, e.v.ill_np, e.tag}) begin
                     bad++;
                     $display("FAIL np_decode %h: got valid=%b ill=%b tag=%h expected valid=1 ill=%b tag=%h",
                              e.v.instr, np_valid, np_illegal, np_tag, e.v.ill_np, e.tag);
                  end
               end
            end
         end
         if (in_valid && in_ready) q.push_back(exp_cur);
      end
   end

   task automatic send(input vec_t v);
      logic acc;
      int   n;
      in_instr = v.instr;
      in_priv  = v.priv;
      in_tag   = tag_ctr;
      exp_cur.v      = v;
      exp_cur.tag    = tag_ctr;
      exp_cur.chk_np = chk_np;
      tag_ctr  = tag_ctr + 32'd1;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (!acc) begin
         bad++;
         $display("FAIL accept_timeout: instr=%h not accepted in %0d cycles", v.instr, n);
      end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (q.size() != 0 || out_valid) begin
         bad++;
         $display("FAIL drain_timeout: %0d entries pending, expected 0", q.size());
      end
   endtask

   task automatic check_reset(input string nm);
      chk(nm, {1'b0, out_valid, in_ready, out_kind, out_csr_addr, out_rd, out_rs1_uimm,
               out_csr_re, out_csr_we, out_illegal, out_tag},
              {1'b0, 1'b0, 1'b1, sysk_invalid, 12'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0});
   endtask

   initial begin
      vec_t ecall_v;
      logic [31:0] held_tag;

      //          instr         priv  kind          re    we    ill   ill_np
      tbl[0]  = '{32'h00000073, 2'd3, sysk_ecall,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{32'h00100073, 2'd0, sysk_ebreak, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{32'h30200073, 2'd1, sysk_mret,   1'b0, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{32'h30200073, 2'd3, sysk_mret,   1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{32'h10200073, 2'd0, sysk_sret,   1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{32'h10200073, 2'd1, sysk_sret,   1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{32'h10500073, 2'd0, sysk_wfi,    1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{32'h30002073, 2'd3, sysk_csrrs,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{32'h30002073, 2'd0, sysk_csrrs,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{32'hC00110F3, 2'd3, sysk_csrrw,  1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{32'hC00020F3, 2'd0, sysk_csrrs,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{32'h00000033, 2'd3, sysk_invalid,1'b0, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{32'h00004073, 2'd3, sysk_invalid,1'b0, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{32'h000000F3, 2'd3, sysk_ecall,  1'b0, 1'b0, 1'b1, 1'b1};
      tbl[14] = '{32'h00200073, 2'd3, sysk_invalid,1'b0, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{32'h3402D073, 2'd3, sysk_csrrwi, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{32'h10007173, 2'd1, sysk_csrrci, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{32'h3000B073, 2'd1, sysk_csrrc,  1'b0, 1'b0, 1'b1, 1'b0};
      ecall_v = tbl[0];

      repeat (3) @(posedge clk);
      #1;
      check_reset("reset_state");
      rst = 1'b0;

      // Decode table, back-to-back at full throughput.
      chk_np = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) send(tbl[i]);
      drain();
      chk_np = 1'b0;

      // Stall: two accepted, third blocked until the consumer drains.
      out_ready = 1'b0;
      send(tbl[7]);
      held_tag = out_tag;
      send(tbl[15]);
      chk("in_ready_after_two", {63'd0, in_ready}, 64'd0);
      in_instr = tbl[16].instr;
      in_priv  = tbl[16].priv;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("stall_hold", {31'd0, out_valid, in_ready, out_tag}, {31'd0, 1'b1, 1'b0, held_tag});
      end
      out_ready = 1'b1;
      drain_chk = 1'b1;
      send(tbl[16]);
      drain();
      drain_chk = 1'b0;

      // Flush with both entries full and a pending input.
      out_ready = 1'b0;
      send(tbl[1]);
      send(tbl[3]);
      in_instr = tbl[5].instr;
      in_priv  = tbl[5].priv;
      in_tag   = 32'hDEAD0001;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_full", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});

      // Flush beats an accept that would otherwise happen this cycle.
      in_valid = 1'b1;
      in_tag   = 32'hDEAD0002;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_vs_accept", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(ecall_v);
      drain();

      // Reset in the middle of a stalled stream.
      out_ready = 1'b0;
      send(tbl[10]);
      send(tbl[17]);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset("midstream_reset");
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(tbl[6]);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
